// File: rtl/round_countdown_timer_if.sv
// Control and status bundle between the game-control FSM and the round countdown timer.
interface round_countdown_timer_if #(
  parameter int unsigned SEC_WIDTH = 7
);
  logic                 start;
  logic                 pause;
  logic                 abort;
  logic                 auto_reload;
  logic                 load_en;
  logic [SEC_WIDTH-1:0] load_secs;
  logic [SEC_WIDTH-1:0] secs_left;
  logic                 running;
  logic                 hit_target;
  logic                 done_pulse;
  logic                 warn;

  modport master (
    output start, pause, abort, auto_reload, load_en, load_secs,
    input  secs_left, running, hit_target, done_pulse, warn
  );

  modport slave (
    input  start, pause, abort, auto_reload, load_en, load_secs,
    output secs_left, running, hit_target, done_pulse, warn
  );
endinterface

// File: rtl/round_countdown_timer.sv
// Programmable seconds countdown for game rounds: load, pause/resume, abort,
// auto-reload, live seconds readout, low-time warning and one-cycle expiry pulse.
module round_countdown_timer #(
  parameter int unsigned TICKS_PER_SEC = 781250,
  parameter int unsigned SEC_WIDTH     = 7,
  parameter int unsigned DEFAULT_SECS  = 60,
  parameter int unsigned WARN_SECS     = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  round_countdown_timer_if.slave  bus
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [SEC_WIDTH-1:0] secs_q, secs_d;
  logic [SEC_WIDTH-1:0] reload_q, reload_d;
  logic [SEC_WIDTH-1:0] load_val;
  logic                 pulse_d;
  logic                 running_d;
  logic                 hit_d;
  logic                 warn_d;
  logic                 running_q;
  logic                 hit_q;
  logic                 warn_q;
  logic                 pulse_q;

  // Next-state logic; priority is abort > start/load > pause > count.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    secs_d   = secs_q;
    reload_d = reload_q;
    pulse_d  = 1'b0;
    load_val = (bus.load_secs == '0) ? SEC_WIDTH'(1) : bus.load_secs;

    case (state_q)
      IDLE, DONE: begin
        if (bus.load_en) begin
          reload_d = load_val;
          secs_d   = load_val;
        end
        if (bus.start) begin
          secs_d  = bus.load_en ? load_val : reload_q;
          presc_d = '0;
          state_d = RUN;
        end
      end
      RUN, PAUSED: begin
        if (bus.abort) begin
          state_d = IDLE;
          secs_d  = reload_q;
          presc_d = '0;
        end else if (bus.pause) begin
          state_d = PAUSED;
        end else begin
          // The resume edge also counts, so a pause loses no cycles.
          state_d = RUN;
          if (presc_q == PW'(TICKS_PER_SEC - 1)) begin
            presc_d = '0;
            if (secs_q == SEC_WIDTH'(1)) begin
              pulse_d = 1'b1;
              if (bus.auto_reload) begin
                secs_d = reload_q;
              end else begin
                secs_d  = '0;
                state_d = DONE;
              end
            end else begin
              secs_d = secs_q - SEC_WIDTH'(1);
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    running_d = (state_d == RUN) || (state_d == PAUSED);
    hit_d     = (state_d == IDLE) || (state_d == DONE);
    warn_d    = running_d && (secs_d != '0) && (secs_d <= SEC_WIDTH'(WARN_SECS));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      secs_q    <= SEC_WIDTH'(DEFAULT_SECS);
      reload_q  <= SEC_WIDTH'(DEFAULT_SECS);
      pulse_q   <= 1'b0;
      running_q <= 1'b0;
      hit_q     <= 1'b1;
      warn_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      secs_q    <= secs_d;
      reload_q  <= reload_d;
      pulse_q   <= pulse_d;
      running_q <= running_d;
      hit_q     <= hit_d;
      warn_q    <= warn_d;
    end
  end

  assign bus.secs_left  = secs_q;
  assign bus.running    = running_q;
  assign bus.hit_target = hit_q;
  assign bus.done_pulse = pulse_q;
  assign bus.warn       = warn_q;

endmodule

// File: tb/tb_round_countdown_timer.sv
// Directed bench for round_countdown_timer: expected expiry edges are queued by
// the stimulus and matched by a monitor against each done_pulse.
module tb_round_countdown_timer;

  localparam int unsigned TPS = 4;
  localparam int unsigned SW  = 6;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   edge_n = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_q[$];

  round_countdown_timer_if #(.SEC_WIDTH(SW)) bus ();

  round_countdown_timer #(
    .TICKS_PER_SEC(TPS),
    .SEC_WIDTH    (SW),
    .DEFAULT_SECS (3),
    .WARN_SECS    (1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Monitor: each done_pulse must match the oldest queued expiry edge.
  always @(negedge clk) begin
    if (bus.done_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done_pulse: got pulse at edge %0d expected none", edge_n);
      end else begin
        chk("done_pulse_edge", edge_n, exp_q.pop_front());
      end
    end
  end

  task automatic at_edge(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  task automatic do_start(input bit ld, input logic [SW-1:0] val, input int n,
                          input bit exp_pulse, output int e0);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.load_en   = ld;
    bus.load_secs = val;
    e0 = edge_n + 1;
    if (exp_pulse) exp_q.push_back(e0 + n * TPS);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.load_en = 1'b0;
  endtask

  task automatic do_load(input logic [SW-1:0] val);
    @(negedge clk);
    bus.load_en   = 1'b1;
    bus.load_secs = val;
    @(negedge clk);
    bus.load_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int e0;
    bit saw_bad;
    bus.start = 1'b0; bus.pause = 1'b0; bus.abort = 1'b0;
    bus.auto_reload = 1'b0; bus.load_en = 1'b0; bus.load_secs = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_secs_left", bus.secs_left, 3);
    chk("rst_running", bus.running, 0);
    chk("rst_hit_target", bus.hit_target, 1);
    chk("rst_warn", bus.warn, 0);
    chk("rst_done_pulse", bus.done_pulse, 0);
    reset = 1'b1;

    // One-shot default countdown
    do_start(1'b0, '0, 3, 1'b1, e0);
    at_edge(e0);      chk("t1_secs_e0", bus.secs_left, 3);
                      chk("t1_hit_run", bus.hit_target, 0);
                      chk("t1_running", bus.running, 1);
    at_edge(e0 + 3);  chk("t1_secs_e3", bus.secs_left, 3);
    at_edge(e0 + 4);  chk("t1_secs_e4", bus.secs_left, 2);
                      chk("t1_warn_2", bus.warn, 0);
    at_edge(e0 + 8);  chk("t1_secs_e8", bus.secs_left, 1);
                      chk("t1_warn_1", bus.warn, 1);
    at_edge(e0 + 12); chk("t1_secs_e12", bus.secs_left, 0);
                      chk("t1_hit_done", bus.hit_target, 1);
                      chk("t1_warn_done", bus.warn, 0);
    at_edge(e0 + 16); chk("t1_hit_stays", bus.hit_target, 1);
                      chk("t1_done_stays", bus.secs_left, 0);

    // Load with start, then zero-clamped load
    do_start(1'b1, 6'd5, 5, 1'b1, e0);
    at_edge(e0);      chk("t2_secs_load5", bus.secs_left, 5);
    at_edge(e0 + 20); chk("t2_secs_end", bus.secs_left, 0);
    do_start(1'b1, 6'd0, 1, 1'b1, e0);
    at_edge(e0);      chk("t2_secs_clamp", bus.secs_left, 1);
                      chk("t2_warn_clamp", bus.warn, 1);
    at_edge(e0 + 5);  chk("t2_hit_clamp", bus.hit_target, 1);
    do_load(6'd3);    chk("t2_load_only", bus.secs_left, 3);

    // Pause sampled on edges E0+2..E0+8
    do_start(1'b0, '0, 3, 1'b0, e0);
    exp_q.push_back(e0 + 19);
    at_edge(e0 + 1);
    bus.pause = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      at_edge(e0 + k);
      chk("t3_pause_secs", bus.secs_left, 3);
      chk("t3_pause_running", bus.running, 1);
    end
    bus.pause = 1'b0;
    at_edge(e0 + 11); chk("t3_secs_resumed", bus.secs_left, 2);
    at_edge(e0 + 20); chk("t3_hit_end", bus.hit_target, 1);

    // Auto-reload: three pulses, never shows 0
    bus.auto_reload = 1'b1;
    do_start(1'b0, '0, 3, 1'b1, e0);
    exp_q.push_back(e0 + 24);
    exp_q.push_back(e0 + 36);
    saw_bad = 1'b0;
    while (edge_n < e0 + 37) begin
      if (bus.secs_left == '0 || bus.running !== 1'b1) saw_bad = 1'b1;
      if (edge_n == e0 + 12) chk("t4_secs_reload", bus.secs_left, 3);
      if (edge_n == e0 + 16) chk("t4_secs_after", bus.secs_left, 2);
      @(negedge clk);
    end
    chk("t4_never_zero", saw_bad, 0);
    bus.abort = 1'b1;
    bus.auto_reload = 1'b0;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("t4_abort_hit", bus.hit_target, 1);
    chk("t4_abort_secs", bus.secs_left, 3);

    // Abort mid-run
    do_start(1'b0, '0, 3, 1'b0, e0);
    at_edge(e0 + 5);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("t5_abort_hit", bus.hit_target, 1);
    chk("t5_abort_running", bus.running, 0);
    chk("t5_abort_secs", bus.secs_left, 3);
    repeat (16) @(negedge clk);

    // Abort on the expiry edge suppresses the pulse
    do_start(1'b0, '0, 3, 1'b0, e0);
    at_edge(e0 + 11);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("t5_abort_exp_secs", bus.secs_left, 3);
    chk("t5_abort_exp_hit", bus.hit_target, 1);
    repeat (4) @(negedge clk);

    // start/load_en ignored while running
    do_start(1'b0, '0, 3, 1'b1, e0);
    at_edge(e0 + 4);
    bus.start = 1'b1; bus.load_en = 1'b1; bus.load_secs = 6'd9;
    @(negedge clk);
    bus.start = 1'b0; bus.load_en = 1'b0;
    chk("t5_ignore_secs", bus.secs_left, 2);
    at_edge(e0 + 13); chk("t5_ignore_hit", bus.hit_target, 1);
    do_start(1'b0, '0, 3, 1'b1, e0);
    chk("t5_reload_kept", bus.secs_left, 3);
    at_edge(e0 + 13);

    // Async reset mid-cycle
    do_start(1'b1, 6'd5, 5, 1'b0, e0);
    at_edge(e0 + 13); chk("t6_secs_pre", bus.secs_left, 2);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_secs", bus.secs_left, 3);
    chk("t6_rst_running", bus.running, 0);
    chk("t6_rst_hit", bus.hit_target, 1);
    chk("t6_rst_warn", bus.warn, 0);
    chk("t6_rst_pulse", bus.done_pulse, 0);
    @(negedge clk);
    reset = 1'b1;
    do_start(1'b0, '0, 3, 1'b1, e0);
    chk("t6_reload_default", bus.secs_left, 3);
    at_edge(e0 + 14);

    chk("pending_pulses", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/round_countdown_timer.md
Name: round_countdown_timer

Overview:
- Parametrised, programmable seconds countdown timer for game-round timing; successor to the fixed one-shot 60 s timer.
- Adds runtime-loadable duration, pause/resume, abort, auto-reload mode, a live seconds-remaining readout, a low-time warning flag and a one-cycle expiry pulse.
- Sits between the game-control FSM and the display/score logic; hit_target keeps its old meaning (idle or expired) so existing consumers can be rewired without change.

Parameters:
- TICKS_PER_SEC, 781250: clk cycles per second (1.28 us period). Must be ≥ 2. Prescaler width is $clog2(TICKS_PER_SEC).
- SEC_WIDTH, 7: width of the seconds counter and load value.
- DEFAULT_SECS, 60: reload value after reset. Must be in 1..2^SEC_WIDTH-1.
- WARN_SECS, 10: warn asserts when secs_left ≤ WARN_SECS.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  begin countdown; accepted in IDLE/DONE only
- pause  in  1  level; while high in RUN, the timer is frozen
- abort  in  1  return to IDLE from RUN/PAUSED; no expiry pulse
- auto_reload  in  1  mode: 1 = periodic, 0 = one-shot; sampled at each expiry
- load_en  in  1  write load_secs into the reload register; accepted in IDLE/DONE only
- load_secs  in  SEC_WIDTH  new duration in seconds; 0 is clamped to 1
- secs_left  out  SEC_WIDTH  seconds remaining (registered)
- running  out  1  state is RUN or PAUSED
- hit_target  out  1  state is IDLE or DONE
- done_pulse  out  1  one-cycle pulse at expiry
- warn  out  1  (RUN|PAUSED) and 0 < secs_left ≤ WARN_SECS

Behaviour:
- Reset (reset==0, async): state IDLE; reload_val=DEFAULT_SECS; secs_left=DEFAULT_SECS; prescaler=0; done_pulse=0. Consequently running=0, hit_target=1 and warn=0.
- States: IDLE, RUN, PAUSED, DONE. Two-bit encoding; an unused encoding goes to IDLE.
- Input priority each edge: abort > start/load > pause > count.
- IDLE/DONE:
  - load_en: reload_val and secs_left take max(load_secs,1).
  - start: secs_left takes reload_val (or the new load value if load_en is in the same cycle), prescaler=0, next state RUN.
  - pause and abort are ignored.
- RUN:
  - pause=1: next state PAUSED. The prescaler and secs_left do not change on that edge.
  - Otherwise the prescaler increments. At prescaler==TICKS_PER_SEC-1 it wraps to 0 and secs_left decrements.
  - Expiry is a terminal tick with secs_left==1. On that edge done_pulse is 1 for the following cycle.
  - Expiry with auto_reload=1: secs_left takes reload_val and the state stays RUN. secs_left never shows 0.
  - Expiry with auto_reload=0: secs_left takes 0 and next state DONE.
- PAUSED: all counters are held. pause=0 returns to RUN, and counting resumes from the held prescaler value (no lost or extra cycles).
- abort in RUN/PAUSED: next state IDLE, secs_left takes reload_val, prescaler=0, no done_pulse. This includes the expiry cycle: abort suppresses the pulse.
- Ignored inputs: start and load_en in RUN/PAUSED. DONE stays DONE until start.
- Latency: start accepted at edge E0 gives the first decrement at edge E0+TICKS_PER_SEC. Expiry occurs at edge E0+N·TICKS_PER_SEC, where N = secs_left at start, excluding paused cycles.
- done_pulse is registered, with no combinational path from inputs. warn, running and hit_target decode from the registered state/secs_left only.
- Reset asserted mid-count returns immediately to the reset values; reload_val also returns to DEFAULT_SECS.

Test Plan:
Bench params: TICKS_PER_SEC=4, SEC_WIDTH=6, DEFAULT_SECS=3, WARN_SECS=1.
1. Reset release, start at E0, one-shot:
   - secs_left reads 3,2,1 and then 0 at edges E0+4, +8, +12.
   - done_pulse high exactly 1 cycle after E0+12.
   - hit_target goes 1→0→1 and stays 1 in DONE.
   - warn is high while secs_left==1.
2. Load then start:
   - load_secs=5 with load_en and start in the same cycle: expiry at E0+20.
   - load_secs=0: clamps, expiry at E0+4.
3. Pause:
   - Assert pause for 7 cycles starting at E0+2: expiry moves to E0+19.
   - secs_left and running are stable (running=1) throughout the pause.
4. Auto-reload:
   - auto_reload=1: done_pulse at E0+12, +24 and +36.
   - secs_left goes 3,2,1,3,… and never 0; state stays RUN.
5. Abort and ignored inputs:
   - abort at E0+6: IDLE, secs_left=3, no done_pulse.
   - abort on the expiry edge: pulse suppressed.
   - start or load_en during RUN: no effect.
6. Async reset:
   - Drop reset mid-cycle during RUN with secs_left=2: outputs return to reset values before the next clk edge.
   - reload_val returns to 3.
